// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, access sizes and fault codes for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;
  function automatic size_t dec_size(input logic by, input logic half);
    return by ? SZ_BYTE : half ? SZ_HALF : SZ_WORD;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte enables, store-lane replication and load lane extraction/extension
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_t       i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsign,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];
  always_comb begin
    o_be    = i_size == SZ_BYTE ? 4'b0001 << i_off
            : i_size == SZ_HALF ? 4'b0011 << {i_off[1], 1'b0} : 4'b1111;
    o_wdata = i_size == SZ_BYTE ? {4{i_wdata[7:0]}}
            : i_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata = i_size == SZ_BYTE ? {{24{~i_unsign & w_byte[7]}}, w_byte}
            : i_size == SZ_HALF ? {{16{~i_unsign & w_half[15]}}, w_half} : i_rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle req/ack data-memory stage; LSU_MISALIGN_TRAP_EN enables the misaligned-access trap
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        by,
  input  logic        half,
  input  logic        unsign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  state_t      r_state, w_next;
  size_t       r_size, w_size;
  logic [31:0] r_addr, r_wdata, r_rdata, r_cnt, w_rext;
  logic [1:0]  r_fcode, w_fcode;
  logic [3:0]  w_be;
  logic        r_unsign, r_we, r_req, w_acc, w_mis, w_to;

  assign w_size = dec_size(by, half);
  assign w_acc  = mem_read | mem_write;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = (w_size == SZ_HALF && addr[0]) || (w_size == SZ_WORD && addr[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif
  // an ack in the expiry cycle takes precedence over the timeout
  assign w_to = TIMEOUT != 0 && r_cnt == 32'(TIMEOUT - 1) && !bus_ack;

  always_comb begin
    w_next  = r_state == IDLE ? (w_acc ? (w_mis ? DONE : BUSY) : IDLE)
            : r_state == BUSY ? ((bus_ack || w_to) ? DONE : BUSY) : IDLE;
    w_fcode = r_state == IDLE && w_acc && w_mis ? FC_MISALIGN
            : r_state == BUSY && w_to ? FC_TIMEOUT : FC_NONE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
      r_size   <= SZ_BYTE;
      r_unsign <= 1'b0;
      r_we     <= 1'b0;
      r_req    <= 1'b0;
      r_fcode  <= FC_NONE;
    end else begin
      r_fcode <= w_fcode;
      if (r_state == IDLE && w_acc) begin
        r_addr   <= addr;
        r_wdata  <= wdata;
        r_size   <= w_size;
        r_unsign <= unsign;
        r_we     <= mem_write;
        r_req    <= !w_mis;
        r_cnt    <= '0;
        if (w_mis) r_rdata <= '0;
      end
      if (r_state == BUSY) begin
        if (bus_ack) begin
          r_req <= 1'b0;
          if (!r_we) r_rdata <= w_rext;
        end else if (w_to) begin
          r_req   <= 1'b0;
          r_rdata <= '0;
        end else r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  lsu_lane_align u_align (
    .i_size  (r_size),
    .i_off   (r_addr[1:0]),
    .i_unsign(r_unsign),
    .i_wdata (r_wdata),
    .i_rdata (bus_rdata),
    .o_be    (w_be),
    .o_wdata (bus_wdata),
    .o_rdata (w_rext)
  );

  assign stall      = (r_state == IDLE && w_acc) || r_state == BUSY;
  assign rdata      = r_rdata;
  assign fault      = r_fcode != FC_NONE;
  assign fault_code = r_fcode;
  assign bus_req    = r_req;
  assign bus_we     = r_we & r_req;
  assign bus_addr   = {r_addr[31:2], 2'b00};
  assign bus_be     = r_req ? w_be : 4'b0000;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for load_store_unit (TIMEOUT=4)
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, by = 1'b0, half = 1'b0, unsign = 1'b0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        stall, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [1:0]  fault_code;
  logic [3:0]  bus_be;
  int          errors = 0, checks = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .by(by), .half(half),
    .unsign(unsign), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .fault(fault),
    .fault_code(fault_code), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic b, input logic h,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; by = b; half = h; unsign = u; addr = a; wdata = wd;
  endtask

  task automatic do_access(input string tag, input logic rd, input logic wr, input logic b,
                           input logic h, input logic u, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] brd, input int waits, input logic [3:0] ebe,
                           input logic [31:0] ewd, input logic [31:0] erd);
    drive(rd, wr, b, h, u, a, wd);
    #1 chk({tag, ".idle_stall"}, 32'(stall), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    #1 chk({tag, ".req"}, 32'(bus_req), 32'd1);
    chk({tag, ".stall"}, 32'(stall), 32'd1);
    chk({tag, ".addr"}, bus_addr, a & 32'hFFFF_FFFC);
    chk({tag, ".be"}, 32'(bus_be), 32'(ebe));
    chk({tag, ".we"}, 32'(bus_we), 32'(wr));
    chk({tag, ".wdata"}, bus_wdata, ewd);
    for (int i = 0; i < waits; i++) begin
      step();
      chk({tag, ".wait_req"}, 32'(bus_req), 32'd1);
    end
    bus_ack = 1'b1;
    bus_rdata = brd;
    step();
    bus_ack = 1'b0;
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    chk({tag, ".done_req"}, 32'(bus_req), 32'd0);
    chk({tag, ".rdata"}, rdata, erd);
    chk({tag, ".fault"}, {29'd0, fault, fault_code}, 32'd0);
    step();
    chk({tag, ".idle_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", 32'(bus_req), 32'd0);
    chk("rst.be_we", {27'd0, bus_be, bus_we}, 32'd0);
    chk("rst.addr", bus_addr, 32'd0);
    chk("rst.wdata", bus_wdata, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.fault", {29'd0, fault, fault_code}, 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    rst = 1'b0;
    step();
    do_access("sw",  0, 1, 0, 0, 0, 32'h104, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0);
    do_access("lb",  1, 0, 1, 0, 0, 32'h203, 32'h0,        32'h80AABBCC, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
    do_access("lbu", 1, 0, 1, 0, 1, 32'h203, 32'h0,        32'h80AABBCC, 0, 4'b1000, 32'h0, 32'h00000080);
    chk("hold.rdata", rdata, 32'h00000080);
    do_access("lhu", 1, 0, 0, 1, 1, 32'h302, 32'h0,        32'h92345678, 0, 4'b1100, 32'h0, 32'h00009234);
    do_access("lh",  1, 0, 0, 1, 0, 32'h302, 32'h0,        32'h92345678, 0, 4'b1100, 32'h0, 32'hFFFF9234);
    do_access("sb",  0, 1, 1, 0, 0, 32'h201, 32'h12345678, 32'h0,        1, 4'b0010, 32'h78787878, 32'hFFFF9234);
    do_access("sh",  0, 1, 0, 1, 0, 32'h302, 32'hABCD1234, 32'h0,        0, 4'b1100, 32'h12341234, 32'hFFFF9234);
    do_access("lw",  1, 0, 0, 0, 0, 32'h100, 32'h0,        32'h13572468, 2, 4'b1111, 32'h0, 32'h13572468);
    do_access("lbp", 1, 0, 1, 0, 0, 32'h200, 32'h0,        32'h1234567F, 0, 4'b0001, 32'h0, 32'h0000007F);
    do_access("rdwr", 1, 1, 0, 0, 0, 32'h010, 32'h55AA55AA, 32'hFFFFFFFF, 0, 4'b1111, 32'h55AA55AA, 32'h0000007F);
    drive(1, 0, 0, 0, 0, 32'h500, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("to.req", 32'(bus_req), 32'd1);
      chk("to.stall", 32'(stall), 32'd1);
      step();
    end
    chk("to.done_req", 32'(bus_req), 32'd0);
    chk("to.fault", {30'd0, fault, stall}, 32'd2);
    chk("to.code", 32'(fault_code), 32'd2);
    chk("to.rdata", rdata, 32'd0);
    step();
    chk("to.idle_fault", 32'(fault), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    drive(0, 1, 0, 1, 0, 32'h401, 32'h0000BEEF);
    #1 chk("mis.idle_stall", 32'(stall), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("mis.req", 32'(bus_req), 32'd0);
    chk("mis.fault", {30'd0, fault, stall}, 32'd2);
    chk("mis.code", 32'(fault_code), 32'd1);
    step();
    chk("mis.idle_fault", 32'(fault), 32'd0);
`else
    do_access("mis", 0, 1, 0, 1, 0, 32'h401, 32'h0000BEEF, 32'h0, 0, 4'b0011, 32'hBEEFBEEF, 32'h0);
`endif
    drive(1, 0, 0, 0, 0, 32'h600, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("rb.req", 32'(bus_req), 32'd1);
    step();
    rst = 1'b1;
    #1 chk("rb.req_async", 32'(bus_req), 32'd0);
    chk("rb.stall_async", 32'(stall), 32'd0);
    step();
    rst = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    step();
    step();
    chk("rb.late_req", 32'(bus_req), 32'd0);
    chk("rb.late_stall", 32'(stall), 32'd0);
    chk("rb.late_fault", 32'(fault), 32'd0);
    chk("rb.late_rdata", rdata, 32'd0);
    bus_ack = 1'b0;
    do_access("lbu1", 1, 0, 1, 0, 1, 32'h601, 32'h0, 32'h0000AB00, 0, 4'b0010, 32'h0, 32'h000000AB);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the control unit in the execute/memory path. Consumes the control unit's `MemRead`, `MemWrite`, `by`, `half` and `unsign` decode bits together with the ALU-computed address and rs2 data. Drives a word-wide req/ack data bus and stalls the core until the access completes. Returns lane-extracted, sign- or zero-extended load data to the register write-back mux.

## Interface
- `TIMEOUT`, default 255: cycles in BUSY without `bus_ack` before a timeout fault; 0 disables the timeout.
- `clk` in 1: core clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_read` in 1: load request (control unit `MemRead`).
- `mem_write` in 1: store request (control unit `MemWrite`).
- `by` in 1: byte access.
- `half` in 1: halfword access. When neither `by` nor `half` is set, the access is a word.
- `unsign` in 1: zero-extend loads (lbu/lhu).
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `stall` out 1: hold the pipeline.
- `rdata` out 32: extended load data; valid in DONE.
- `fault` out 1: access fault; valid in DONE.
- `fault_code` out 2: 00 none, 01 misaligned, 10 timeout.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 1: write strobe.
- `bus_addr` out 32: word-aligned address; bits [1:0] are always 0.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rdata` in 32: bus read data.
- `bus_ack` in 1: completion from the bus; sampled only in BUSY.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `mem_read|mem_write`: capture addr, wdata, size, unsign and we into registers.
  - If `mem_write` is set, the access is a write, including when `mem_read` is also set.
  - Normal case: go to BUSY with `bus_req`=1.
  - Misaligned with the trap compiled in: go to DONE with no bus activity.
- **BUSY**
  - Hold `bus_req` and all bus outputs stable until `bus_ack`.
  - On `bus_ack`: capture the extended `bus_rdata` into `rdata` (loads only), drop `bus_req`, go to DONE.
  - When the timeout counter reaches `TIMEOUT`: drop `bus_req`, go to DONE with `fault_code`=10.
  - If `bus_ack` and timeout expiry coincide, the ack wins.
- **DONE**
  - Stays for exactly one cycle, then returns to IDLE.
  - `fault` and `fault_code` are valid for that cycle only.
  - `rdata` holds its value until the next capture.
- `stall` = (IDLE && (`mem_read`|`mem_write`)) || BUSY. It is combinational and is low in DONE.
- Byte enables and store data:
  - Byte: `bus_be` = 0001 << addr[1:0]; `bus_wdata` = wdata[7:0] replicated ×4.
  - Half: `bus_be` = 0011 << {addr[1],0}; `bus_wdata` = wdata[15:0] replicated ×2.
  - Word: `bus_be` = 1111; `bus_wdata` = wdata.
- Load extraction:
  - Select the lane by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend from bit 7 or 15 unless `unsign` is set, in which case zero-extend.
  - Word loads pass through unchanged.
- For faulted accesses, `rdata` = 0.
- `bus_ack` outside BUSY is ignored.

## Timing
- Reset values: state IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `rdata`=0, `fault`=0, `fault_code`=00, timeout counter 0.
- Reset is asynchronous. If asserted mid-BUSY, `bus_req` drops immediately and the access is abandoned.
- Minimum access is 3 cycles:
  - cycle 0: IDLE, stall=1.
  - cycle 1: BUSY, ack arrives.
  - cycle 2: DONE, stall=0.
- Each additional wait cycle before `bus_ack` adds one cycle.
- Back-to-back memory instructions: a new access is accepted in the IDLE cycle that follows DONE.
- The timeout counter clears on entry to BUSY and increments once per BUSY cycle without ack.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half with addr[0]=1, or a word with addr[1:0]≠0, takes IDLE→DONE directly.
  - `fault`=1, `fault_code`=01, no `bus_req`.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Offending low address bits are ignored (half treated as aligned on addr[1]; word on addr[31:2]).
  - No fault is raised and the access proceeds normally.

## Structure
- Package `lsu_pkg`:
  - state enum (IDLE/BUSY/DONE);
  - fault-code constants (NONE/MISALIGN/TIMEOUT);
  - size encoding (BYTE/HALF/WORD).
- Sub-module `lsu_lane_align`: purely combinational. Computes `bus_be`, `bus_wdata` and load extraction/extension from the registered size, offset and unsign.
- The FSM, timeout counter and capture registers stay in `load_store_unit`.

## Test plan
- **Word store:** sw, addr 0x104, wdata 0xDEADBEEF, ack on first BUSY cycle → `bus_addr` 0x104, `bus_be` 1111, `bus_we`=1; stall high 2 cycles, DONE on cycle 2.
- **Signed byte load:** lb, addr 0x203, bus_rdata 0x80AABBCC → `bus_be` 1000, `rdata` 0xFFFFFF80. Repeat with lbu → `rdata` 0x00000080.
- **Halfword load:** lhu, addr 0x302, bus_rdata 0x9234_5678 → `rdata` 0x00009234. lh, same address → `rdata` 0xFFFF9234.
- **Timeout:** TIMEOUT=4, no ack → `bus_req` high for 4 BUSY cycles, then DONE with `fault`=1, `fault_code`=10, `rdata`=0.
- **Misaligned access:** sh to 0x401.
  - With `LSU_MISALIGN_TRAP_EN` defined → no `bus_req`, `fault_code`=01.
  - Without the macro → `bus_be` 0011, `bus_addr` 0x400, no fault.
- **Reset mid-BUSY:** assert `rst` during BUSY wait → `bus_req`=0 and `stall` low immediately. After release with no pending request, stays IDLE; a late `bus_ack` is ignored.
